video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_RESOLUTION, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_RESOLUTION, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-004 The block SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, meaning vertical porch and sync widths in lines.
REQ-005 The block SHALL have parameters H_SYNC_POL/V_SYNC_POL, default 0/0, meaning the active sync level.
REQ-006 The block SHALL have port i_clk, input, 1 bit, the pixel clock; one clock, all logic on rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-008 The block SHALL have port o_x, output, 13 bits, current pixel column.
REQ-009 The block SHALL have port o_y, output, 13 bits, current line.
REQ-010 The block SHALL have port o_disp_enable, output, 1 bit, high inside the active area.
REQ-011 The block SHALL have ports o_hsync and o_vsync, outputs, 1 bit each, sync pulses at configured polarity.
REQ-012 The block SHALL have port o_frame_start, output, 1 bit, one-cycle pulse at pixel (0,0).

Function
REQ-013 The block SHALL keep a horizontal counter 0..H_TOTAL-1 (H_TOTAL = sum of H params) advancing every cycle and wrapping to 0.
REQ-014 The block SHALL advance the vertical counter 0..V_TOTAL-1 only on the cycle the horizontal counter wraps; it SHALL wrap to 0 after V_TOTAL-1.
REQ-015 Each axis SHALL decode states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, with ACTIVE starting at count 0.
REQ-016 All outputs SHALL be registered, with 1 cycle latency from counter state.
REQ-017 o_disp_enable SHALL be high iff both axes are ACTIVE.
REQ-018 o_x/o_y SHALL equal the raw counters in every state, not only while active.
REQ-019 o_hsync SHALL equal H_SYNC_POL during horizontal SYNC, else its inverse; o_vsync likewise with V_SYNC_POL, spanning whole lines.
REQ-020 o_frame_start SHALL pulse for exactly one cycle, coincident with o_x=0, o_y=0.
REQ-021 Counter compares SHALL be 13-bit unsigned; H_TOTAL and V_TOTAL SHALL each be at most 8191, with an elaboration error otherwise.

Reset
REQ-022 While i_rst_n is low, all outputs SHALL hold: o_x=0, o_y=0, o_disp_enable=0, o_frame_start=0, and o_hsync/o_vsync at their inactive level; counters SHALL be 0.
REQ-023 On the first rising edge after release, outputs SHALL reflect position (0,0): o_disp_enable=1 and o_frame_start=1.
REQ-024 Reset asserted mid-frame SHALL take effect immediately (asynchronous assertion) and restart from (0,0).

Configuration
REQ-025 With macro VIDEO_TIMING_SYNC_DELAY_EN defined, o_disp_enable, o_hsync, o_vsync and o_frame_start SHALL be delayed one extra register stage (2-cycle latency) relative to o_x/o_y, to align with a registered pixel pipeline; delay registers SHALL have the reset values of REQ-022.
REQ-026 Without VIDEO_TIMING_SYNC_DELAY_EN, all outputs SHALL have 1-cycle latency per REQ-016.

Structure
REQ-027 A shared package video_timing_pkg SHALL hold the axis state enum (ACTIVE, FRONT, SYNC, BACK) and the default 640x480 timing constants.
REQ-028 A sub-module timing_axis_counter (count, wrap, state decode, advance-enable input) SHALL be instantiated twice, once for horizontal (enable=1) and once for vertical (enable=horizontal wrap).

Verification
REQ-029 Reset release with defaults -> o_disp_enable high for exactly 640 consecutive cycles, then low for 160; line period 800 cycles.
REQ-030 Within each line -> o_hsync low exactly for o_x 656..751 (96 cycles), high otherwise.
REQ-031 Full frame -> o_vsync low for o_y 490..491 (1600 cycles), o_frame_start every 420000 cycles, and o_y wraps 524 -> 0 exactly when o_x wraps 799 -> 0.
REQ-032 Reset asserted at o_x=300, o_y=200 -> outputs take reset values with no clock edge; after release, the first edge gives o_x=0, o_y=0 and o_frame_start=1.
REQ-033 With VIDEO_TIMING_SYNC_DELAY_EN -> o_disp_enable first rises when o_x=1 (one cycle after o_x=0), and o_hsync falls when o_x=657.
REQ-034 With H_SYNC_POL=1, V_SYNC_POL=1 -> sync pulses are high with the same widths as REQ-030/REQ-031, and the reset level is low.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared axis state enum, default 640x480@60 timing constants and the axis decode helper.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package video_timing_pkg;

    localparam int CNT_W         = 13;
    localparam int CNT_MAX_TOTAL = 8191;

    // Default 640x480 timing: horizontal in pixels, vertical in lines.
    localparam int DEF_H_RESOLUTION = 640;
    localparam int DEF_H_FRONT      = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BACK       = 48;
    localparam int DEF_V_RESOLUTION = 480;
    localparam int DEF_V_FRONT      = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BACK       = 33;

    // Each axis walks ACTIVE -> FRONT -> SYNC -> BACK, with ACTIVE starting at count 0.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

    // Map a raw count onto its region given the first count of each later region.
    function automatic axis_state_t axis_decode(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] front_start,
        input logic [CNT_W-1:0] sync_start,
        input logic [CNT_W-1:0] back_start
    );
        if (cnt < front_start) begin
            return ACTIVE;
        end else if (cnt < sync_start) begin
            return FRONT;
        end else if (cnt < back_start) begin
            return SYNC;
        end else begin
            return BACK;
        end
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: wrapping counter 0..TOTAL-1 plus combinational region decode.
// Latency: count updates on the edge where adv_en is high; wrap/state are combinational from count.
// Backpressure: none; the counter holds whenever adv_en is low.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_RESOLUTION,
    parameter int FRONT_LEN  = DEF_H_FRONT,
    parameter int SYNC_LEN   = DEF_H_SYNC,
    parameter int BACK_LEN   = DEF_H_BACK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             adv_en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output axis_state_t      state
);

    localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

    // Wrap is only reported on a cycle that actually advances, so it can enable the next axis.
    assign wrap  = adv_en && (count == LAST);
    assign state = axis_decode(count, FRONT_START, SYNC_START, BACK_START);

    // Advance on enable, returning to 0 after the last count of the axis.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (adv_en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y position, display enable, h/v sync and frame-start pulse.
// Latency: 1 cycle from counters to all outputs; with VIDEO_TIMING_SYNC_DELAY_EN the
// enable/sync/frame-start outputs take 2 cycles while o_x/o_y stay at 1. Backpressure: none, free-running.
module video_timing_gen #(
    parameter int H_RESOLUTION = video_timing_pkg::DEF_H_RESOLUTION,
    parameter int V_RESOLUTION = video_timing_pkg::DEF_V_RESOLUTION,
    parameter int H_FRONT      = video_timing_pkg::DEF_H_FRONT,
    parameter int H_SYNC       = video_timing_pkg::DEF_H_SYNC,
    parameter int H_BACK       = video_timing_pkg::DEF_H_BACK,
    parameter int V_FRONT      = video_timing_pkg::DEF_V_FRONT,
    parameter int V_SYNC       = video_timing_pkg::DEF_V_SYNC,
    parameter int V_BACK       = video_timing_pkg::DEF_V_BACK,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [12:0] o_x,
    output logic [12:0] o_y,
    output logic        o_disp_enable,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start
);

    import video_timing_pkg::*;

    localparam int H_TOTAL = H_RESOLUTION + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_RESOLUTION + V_FRONT + V_SYNC + V_BACK;

    // Counters are 13 bits wide, so totals beyond 8191 cannot be represented.
    if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_err
        $error("video_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, CNT_MAX_TOTAL);
    end
    if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_err
        $error("video_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, CNT_MAX_TOTAL);
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap_unused;
    axis_state_t      h_state;
    axis_state_t      v_state;

    timing_axis_counter #(
        .ACTIVE_LEN (H_RESOLUTION),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK)
    ) u_h_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .adv_en  (1'b1),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .state   (h_state)
    );

    // The vertical axis steps once per line, on the cycle the horizontal counter wraps.
    timing_axis_counter #(
        .ACTIVE_LEN (V_RESOLUTION),
        .FRONT_LEN  (V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK)
    ) u_v_axis (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .adv_en  (h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap_unused),
        .state   (v_state)
    );

    logic de_s1;
    logic hs_s1;
    logic vs_s1;
    logic fs_s1;

    // First output stage: register position and decoded timing flags from the counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x   <= '0;
            o_y   <= '0;
            de_s1 <= 1'b0;
            hs_s1 <= ~H_SYNC_POL;
            vs_s1 <= ~V_SYNC_POL;
            fs_s1 <= 1'b0;
        end else begin
            o_x   <= h_cnt;
            o_y   <= v_cnt;
            de_s1 <= (h_state == ACTIVE) && (v_state == ACTIVE);
            hs_s1 <= (h_state == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vs_s1 <= (v_state == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            fs_s1 <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VIDEO_TIMING_SYNC_DELAY_EN
    // Extra stage so enable/sync line up with a registered pixel pipeline fed by o_x/o_y.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_disp_enable <= 1'b0;
            o_hsync       <= ~H_SYNC_POL;
            o_vsync       <= ~V_SYNC_POL;
            o_frame_start <= 1'b0;
        end else begin
            o_disp_enable <= de_s1;
            o_hsync       <= hs_s1;
            o_vsync       <= vs_s1;
            o_frame_start <= fs_s1;
        end
    end
`else
    assign o_disp_enable = de_s1;
    assign o_hsync       = hs_s1;
    assign o_vsync       = vs_s1;
    assign o_frame_start = fs_s1;
`endif

endmodule
